crc32_append: RTL and testbench

Transmit-path Ethernet FCS generator: the transmit-side counterpart of the receive-path `crc32` checker. It accepts a byte-wide packet stream, pads frames shorter than the minimum length, and computes the IEEE 802.3 CRC-32. It appends the 4-byte FCS after the last byte and moves end-of-packet to the final FCS byte. It sits between the TX frame source and the TX PHY/serializer. It back-pressures its upstream while pad and FCS bytes are emitted.

---
 rtl/crc32_append.sv | 152 +++++++++++++++
 tb/tb_crc32_append.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_append.sv
// Transmit FCS generator: pads short frames, appends IEEE 802.3 CRC-32 (LSB byte first), moves eop to last FCS byte.
// Latency: one registered output stage; accepted byte appears next cycle. Upstream stalled during pad/FCS and on output stall.
// Backpressure: output register loads when !out_valid || stream_out_ready; stream_in_ready is combinational from stream_out_ready.
`timescale 1ns/1ps
module crc32_append #(
    parameter int          P_MIN_LEN  = 60,
    parameter logic [7:0]  P_PAD_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stream_in_startofpacket,
    input  logic       stream_in_endofpacket,
    input  logic       stream_in_valid,
    input  logic [7:0] stream_in_data,
    input  logic       stream_in_error,
    output logic       stream_in_ready,
    output logic       stream_out_startofpacket,
    output logic       stream_out_endofpacket,
    output logic       stream_out_valid,
    output logic [7:0] stream_out_data,
    output logic       stream_out_error,
    input  logic       stream_out_ready
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_DATA  = 2'd1;
    localparam logic [1:0]  S_PAD   = 2'd2;
    localparam logic [1:0]  S_FCS   = 2'd3;
    localparam logic [16:0] MIN_LEN = 17'(P_MIN_LEN);

    // Reflected CRC-32, one byte per call.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [1:0]  state, state_n;
    logic [31:0] crc, crc_n;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic        sticky, sticky_n;
    logic [1:0]  fcs_idx, fcs_idx_n;
    logic        load, accept, emit;
    logic        nxt_sop, nxt_eop, nxt_err;
    logic [7:0]  nxt_dat, crc_sel;

    assign load            = !stream_out_valid || stream_out_ready;
    assign stream_in_ready = rst_n && ((state == S_IDLE) || (state == S_DATA)) && load;
    assign accept          = stream_in_valid && stream_in_ready;
    assign cnt_inc         = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign crc_sel         = crc[{fcs_idx, 3'b000} +: 8];

    always_comb begin
        state_n   = state;
        crc_n     = crc;
        cnt_n     = cnt;
        sticky_n  = sticky;
        fcs_idx_n = fcs_idx;
        emit      = 1'b0;
        nxt_sop   = 1'b0;
        nxt_eop   = 1'b0;
        nxt_err   = 1'b0;
        nxt_dat   = 8'h00;
        case (state)
            S_IDLE: begin
                // Beats without sop are swallowed here.
                if (accept && stream_in_startofpacket) begin
                    emit      = 1'b1;
                    nxt_sop   = 1'b1;
                    nxt_err   = stream_in_error;
                    nxt_dat   = stream_in_data;
                    crc_n     = crc_byte(32'hFFFFFFFF, stream_in_data);
                    cnt_n     = 16'd1;
                    sticky_n  = stream_in_error;
                    fcs_idx_n = 2'd0;
                    if (stream_in_endofpacket)
                        state_n = (MIN_LEN > 17'd1) ? S_PAD : S_FCS;
                    else
                        state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    emit     = 1'b1;
                    nxt_err  = stream_in_error;
                    nxt_dat  = stream_in_data;
                    crc_n    = crc_byte(crc, stream_in_data);
                    cnt_n    = cnt_inc;
                    sticky_n = sticky | stream_in_error;
                    if (stream_in_endofpacket)
                        state_n = ({1'b0, cnt_inc} < MIN_LEN) ? S_PAD : S_FCS;
                end
            end
            S_PAD: begin
                if (load) begin
                    emit    = 1'b1;
                    nxt_dat = P_PAD_BYTE;
                    crc_n   = crc_byte(crc, P_PAD_BYTE);
                    cnt_n   = cnt_inc;
                    if ({1'b0, cnt_inc} >= MIN_LEN)
                        state_n = S_FCS;
                end
            end
            S_FCS: begin
                if (load) begin
                    emit      = 1'b1;
                    // An errored frame sends the raw register, i.e. the inverted FCS.
                    nxt_dat   = sticky ? crc_sel : ~crc_sel;
                    nxt_eop   = (fcs_idx == 2'd3);
                    nxt_err   = (fcs_idx == 2'd3) && sticky;
                    fcs_idx_n = fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3)
                        state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= S_IDLE;
            crc                      <= 32'hFFFFFFFF;
            cnt                      <= 16'd0;
            sticky                   <= 1'b0;
            fcs_idx                  <= 2'd0;
            stream_out_valid         <= 1'b0;
            stream_out_data          <= 8'h00;
            stream_out_startofpacket <= 1'b0;
            stream_out_endofpacket   <= 1'b0;
            stream_out_error         <= 1'b0;
        end else begin
            state   <= state_n;
            crc     <= crc_n;
            cnt     <= cnt_n;
            sticky  <= sticky_n;
            fcs_idx <= fcs_idx_n;
            if (load) begin
                stream_out_valid <= emit;
                if (emit) begin
                    stream_out_data          <= nxt_dat;
                    stream_out_startofpacket <= nxt_sop;
                    stream_out_endofpacket   <= nxt_eop;
                    stream_out_error         <= nxt_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc32_append.sv
// Bench for crc32_append: two instances (no padding / 60-byte minimum) checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_crc32_append;

    typedef struct packed {logic sop; logic eop; logic err; logic [7:0] dat;} beat_t;
    typedef beat_t      beatq_t[$];
    typedef logic [7:0] bq_t[$];
    typedef bit         eq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       isop[2], ieop[2], ivld[2], ierr[2], irdy[2];
    logic       osop[2], oeop[2], ovld[2], oerr[2], ordy[2];
    logic [7:0] idat[2], odat[2];
    bit         throttle[2];
    beatq_t     outq[2];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [31:0] tbl[256];

    crc32_append #(.P_MIN_LEN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .stream_in_startofpacket(isop[0]), .stream_in_endofpacket(ieop[0]),
        .stream_in_valid(ivld[0]), .stream_in_data(idat[0]), .stream_in_error(ierr[0]),
        .stream_in_ready(irdy[0]),
        .stream_out_startofpacket(osop[0]), .stream_out_endofpacket(oeop[0]),
        .stream_out_valid(ovld[0]), .stream_out_data(odat[0]), .stream_out_error(oerr[0]),
        .stream_out_ready(ordy[0]));

    crc32_append dut1 (
        .clk(clk), .rst_n(rst_n),
        .stream_in_startofpacket(isop[1]), .stream_in_endofpacket(ieop[1]),
        .stream_in_valid(ivld[1]), .stream_in_data(idat[1]), .stream_in_error(ierr[1]),
        .stream_in_ready(irdy[1]),
        .stream_out_startofpacket(osop[1]), .stream_out_endofpacket(oeop[1]),
        .stream_out_valid(ovld[1]), .stream_out_data(odat[1]), .stream_out_error(oerr[1]),
        .stream_out_ready(ordy[1]));

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++)
            ordy[i] = throttle[i] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: collects accepted beats and checks that stalled beats hold.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        beat_t held, cur;
        bit    stalled = 1'b0;
        always @(negedge clk) begin
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                cur = {osop[g], oeop[g], oerr[g], odat[g]};
                if (stalled) begin
                    n_cmp++;
                    if (!ovld[g] || cur !== held) begin
                        n_bad++;
                        $display("FAIL stall_hold inst=%0d got vld=%b beat=%h required vld=1 beat=%h", g, ovld[g], cur, held);
                    end
                end
                stalled = ovld[g] && !ordy[g];
                held    = cur;
                if (ovld[g] && ordy[g]) outq[g].push_back(cur);
            end
        end
    end

    // Reference CRC in the non-reflected domain: reflect bytes in, reflect the result out.
    function automatic logic [31:0] nr_upd(logic [31:0] c, logic [7:0] d);
        logic [7:0] r;
        r = {<<{d}};
        return (c << 8) ^ tbl[c[31:24] ^ r];
    endfunction

    function automatic beat_t mk(logic s, logic eo, logic er, logic [7:0] d);
        beat_t b;
        b.sop = s; b.eop = eo; b.err = er; b.dat = d;
        return b;
    endfunction

    function automatic beatq_t build_exp(bq_t d, eq_t e, int min_len);
        beatq_t      x;
        bit          st;
        logic [31:0] c, r, fcs;
        st = 1'b0;
        c  = 32'hFFFFFFFF;
        for (int k = 0; k < d.size(); k++) begin
            x.push_back(mk(k == 0, 1'b0, e[k], d[k]));
            st = st | e[k];
            c  = nr_upd(c, d[k]);
        end
        for (int k = d.size(); k < min_len; k++) begin
            x.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00));
            c = nr_upd(c, 8'h00);
        end
        r   = {<<{c}};
        fcs = st ? r : ~r;
        for (int b = 0; b < 4; b++)
            x.push_back(mk(1'b0, b == 3, (b == 3) && st, fcs[8*b +: 8]));
        return x;
    endfunction

    function automatic logic [31:0] residue(beatq_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[k]) c = nr_upd(c, q[k].dat);
        return c;
    endfunction

    function automatic int count_diff(beatq_t a, beatq_t b);
        int n;
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int k = 0; k < a.size() && k < b.size(); k++)
            if (a[k] !== b[k]) n++;
        return n;
    endfunction

    task automatic drive_beat(input int i, input logic s, input logic eo, input logic er,
                              input logic [7:0] d, output int waits);
        logic acc;
        ivld[i] = 1'b1; isop[i] = s; ieop[i] = eo; ierr[i] = er; idat[i] = d;
        waits = 0;
        forever begin
            @(negedge clk);
            acc = irdy[i];
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 5000) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout inst=%0d waited=%0d required<=5000", i, waits);
                break;
            end
        end
        ivld[i] = 1'b0; isop[i] = 1'b0; ieop[i] = 1'b0; ierr[i] = 1'b0;
    endtask

    task automatic send_frame(input int i, input bq_t d, input eq_t e, input bit gaps);
        int w;
        for (int k = 0; k < d.size(); k++) begin
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            drive_beat(i, k == 0, k == d.size() - 1, e[k], d[k], w);
        end
    endtask

    task automatic grab(input int i, input int n, output beatq_t got);
        int t;
        t = 0;
        got.delete();
        while (outq[i].size() < n && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        while (got.size() < n && outq[i].size() > 0) got.push_back(outq[i].pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({irdy[i], ovld[i], osop[i], oeop[i], oerr[i], odat[i]} !== 13'h0) begin
                n_bad++;
                $display("FAIL reset_outputs inst=%0d got=%h required=0", i,
                         {irdy[i], ovld[i], osop[i], oeop[i], oerr[i], odat[i]});
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (irdy[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL ready_after_reset inst=%0d got=%b required=1", i, irdy[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_check_value();
        bq_t        s;
        eq_t        e;
        beatq_t     got, exp;
        logic [4:0] rd;
        logic [31:0] got_fcs;
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(0, s, e, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rd[k] = irdy[0];
        end
        n_cmp++;
        if (rd !== 5'b10000) begin
            n_bad++;
            $display("FAIL fcs_ready_window got=%b required=10000", rd);
        end
        grab(0, 13, got);
        exp = build_exp(s, e, 0);
        n_cmp++;
        if (count_diff(exp, got) != 0) begin
            n_bad++;
            $display("FAIL check_frame beats_differ=%0d got_len=%0d required_len=13", count_diff(exp, got), got.size());
        end
        got_fcs = (got.size() == 13) ? {got[12].dat, got[11].dat, got[10].dat, got[9].dat} : 32'h0;
        n_cmp++;
        if (got_fcs !== 32'hCBF43926) begin
            n_bad++;
            $display("FAIL check_value got=%h required=cbf43926", got_fcs);
        end
        n_cmp++;
        if (residue(got) !== 32'hC704DD7B) begin
            n_bad++;
            $display("FAIL check_residue got=%h required=c704dd7b", residue(got));
        end
    endtask

    task automatic test_pad();
        bq_t    s;
        eq_t    e;
        beatq_t got, exp;
        int     n;
        s = '{8'hAA};
        e = '{0};
        send_frame(1, s, e, 1'b0);
        n = 0;
        @(negedge clk);
        while (!irdy[1] && n < 200) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n != 63) begin
            n_bad++;
            $display("FAIL pad_ready_low got=%0d cycles required=63", n);
        end
        grab(1, 64, got);
        exp = build_exp(s, e, 60);
        n_cmp++;
        if (got.size() != 64 || count_diff(exp, got) != 0) begin
            n_bad++;
            $display("FAIL pad_frame got_len=%0d required_len=64 beats_differ=%0d", got.size(), count_diff(exp, got));
        end
        n_cmp++;
        if (residue(got) !== 32'hC704DD7B) begin
            n_bad++;
            $display("FAIL pad_residue got=%h required=c704dd7b", residue(got));
        end
    endtask

    task automatic test_error();
        bq_t         s;
        eq_t         e, ok;
        beatq_t      got, exp;
        logic [33:0] obs;
        s  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        e  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        ok = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(0, s, e, 1'b0);
        grab(0, 13, got);
        exp = build_exp(s, e, 0);
        n_cmp++;
        if (count_diff(exp, got) != 0) begin
            n_bad++;
            $display("FAIL err_frame beats_differ=%0d got_len=%0d required_len=13", count_diff(exp, got), got.size());
        end
        obs = (got.size() == 13) ? {got[2].err, got[12].err, got[12].dat, got[11].dat, got[10].dat, got[9].dat} : 34'h0;
        n_cmp++;
        if (obs !== {2'b11, 32'h340BC6D9}) begin
            n_bad++;
            $display("FAIL err_fcs got=%h required=%h", obs, {2'b11, 32'h340BC6D9});
        end
        n_cmp++;
        if (residue(got) === 32'hC704DD7B) begin
            n_bad++;
            $display("FAIL err_residue got=%h required!=c704dd7b", residue(got));
        end
        send_frame(0, s, ok, 1'b0);
        grab(0, 13, got);
        obs = (got.size() == 13) ? {got[2].err, got[12].err, got[12].dat, got[11].dat, got[10].dat, got[9].dat} : 34'h0;
        n_cmp++;
        if (obs !== {2'b00, 32'hCBF43926}) begin
            n_bad++;
            $display("FAIL err_cleared got=%h required=%h", obs, {2'b00, 32'hCBF43926});
        end
    endtask

    task automatic test_random();
        bq_t    d;
        eq_t    e;
        beatq_t got, exp;
        int     len;
        bit     bad_frame;
        throttle[1] = 1'b1;
        for (int f = 0; f < 100; f++) begin
            len = (f == 0) ? 1518 : (f == 1) ? 1 : $urandom_range(1, 160);
            d.delete();
            e.delete();
            bad_frame = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < len; k++) begin
                d.push_back(8'($urandom));
                e.push_back(1'b0);
            end
            if (bad_frame) e[$urandom_range(0, len - 1)] = 1'b1;
            send_frame(1, d, e, 1'b1);
            grab(1, ((len > 60) ? len : 60) + 4, got);
            exp = build_exp(d, e, 60);
            n_cmp++;
            if (count_diff(exp, got) != 0) begin
                n_bad++;
                $display("FAIL rand_frame f=%0d len=%0d beats_differ=%0d got_len=%0d required_len=%0d",
                         f, len, count_diff(exp, got), got.size(), exp.size());
            end
            n_cmp++;
            if ((residue(got) === 32'hC704DD7B) == bad_frame) begin
                n_bad++;
                $display("FAIL rand_residue f=%0d got=%h err_frame=%0d", f, residue(got), bad_frame);
            end
        end
        throttle[1] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (outq[1].size() != 0) begin
            n_bad++;
            $display("FAIL rand_extra_beats got=%0d required=0", outq[1].size());
        end
    endtask

    task automatic test_reset_mid();
        bq_t    d;
        eq_t    e;
        beatq_t got, exp;
        int     w;
        for (int k = 0; k < 20; k++) drive_beat(1, k == 0, 1'b0, 1'b0, 8'($urandom), w);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ovld[1] !== 1'b0 || irdy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got vld=%b rdy=%b required 0 0", ovld[1], irdy[1]);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        outq[1].delete();
        for (int k = 0; k < 64; k++) begin
            d.push_back(8'($urandom));
            e.push_back(1'b0);
        end
        drive_beat(1, 1'b1, 1'b0, 1'b0, d[0], w);
        n_cmp++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL sop_after_reset got_waits=%0d required=0", w);
        end
        for (int k = 1; k < 64; k++) drive_beat(1, 1'b0, k == 63, 1'b0, d[k], w);
        grab(1, 68, got);
        exp = build_exp(d, e, 60);
        n_cmp++;
        if (count_diff(exp, got) != 0) begin
            n_bad++;
            $display("FAIL post_reset_frame beats_differ=%0d got_len=%0d required_len=68", count_diff(exp, got), got.size());
        end
        n_cmp++;
        if (residue(got) !== 32'hC704DD7B) begin
            n_bad++;
            $display("FAIL post_reset_residue got=%h required=c704dd7b", residue(got));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n) << 24;
            for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
            tbl[n] = c;
        end
        for (int i = 0; i < 2; i++) begin
            isop[i] = 1'b0; ieop[i] = 1'b0; ivld[i] = 1'b0; ierr[i] = 1'b0; idat[i] = 8'h00;
            ordy[i] = 1'b1; throttle[i] = 1'b0;
        end
        test_reset();
        test_check_value();
        test_pad();
        test_error();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
